// File: rtl/uart_boot_loader_pkg.sv
// boot_pkg: shared state encodings and baud-rate helper for the UART boot loader.
package boot_pkg;
   typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} loader_state_t;
   typedef enum logic [1:0] {IDLE, START, BITS, STOP} rx_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction
endpackage

// File: rtl/uart_boot_loader_rx.sv
// uart_rx: 8N1 receiver with 2-FF synchronizer, glitch-rejecting start detect and centre sampling.
module uart_rx
   import boot_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx,
   output logic       o_valid,
   output logic [7:0] o_data,
   output logic       o_ferr
);
   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   rx_state_t      r_state, w_state_nxt;
   logic [1:0]     r_sync;
   logic           r_prev;
   logic [CW-1:0]  r_cnt;
   logic [2:0]     r_bit;
   logic           w_rx, w_half, w_full;

   assign w_rx   = r_sync[1];
   assign w_half = r_cnt == CW'(CLKS_PER_BIT / 2 - 1);
   assign w_full = r_cnt == CW'(CLKS_PER_BIT - 1);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = (r_prev && !w_rx) ? START : IDLE;
         START:   w_state_nxt = !w_half ? START : w_rx ? IDLE : BITS;
         BITS:    w_state_nxt = (w_full && r_bit == 3'd7) ? STOP : BITS;
         STOP:    w_state_nxt = w_full ? IDLE : STOP;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_sync  <= 2'b11;
         r_prev  <= 1'b1;
         r_cnt   <= '0;
         r_bit   <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_ferr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sync  <= {r_sync[0], i_rx};
         r_prev  <= w_rx;
         // timer restarts on every state change and at each data-bit centre
         r_cnt   <= (r_state == IDLE || w_state_nxt != r_state || (r_state == BITS && w_full)) ? '0 : r_cnt + 1'b1;
         if (r_state == BITS && w_full) begin
            o_data <= {w_rx, o_data[7:1]};
            r_bit  <= r_bit + 3'd1;
         end
         o_valid <= r_state == STOP && w_full;
         if (r_state == STOP && w_full) o_ferr <= !w_rx;
      end
   end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a checksummed program image over UART, writes it to imem,
// and releases the core reset only once the whole image has been accepted.
module uart_boot_loader
   import boot_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 115200,
   parameter int IMEM_WORDS = 1024,
   parameter int ADDR_W     = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              load_done,
   output logic              load_error
);
   localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
   loader_state_t   r_state, w_state_nxt;
   logic [1:0]      r_byte_cnt;
   logic [7:0]      r_csum;
   logic [31:0]     r_n, r_word, w_n_nxt, w_word_nxt;
   logic [ADDR_W:0] r_word_idx;
   logic            r_we;
   logic            w_rx_valid, w_rx_ferr, w_acc, w_word_last;
   logic [7:0]      w_rx_data;

   uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
      .clk     (clk),
      .rst     (rst),
      .i_rx    (uart_rx),
      .o_valid (w_rx_valid),
      .o_data  (w_rx_data),
      .o_ferr  (w_rx_ferr)
   );

   assign imem_we    = r_we;
   assign core_rst   = r_state != DONE;
   assign load_done  = r_state == DONE;
   assign load_error = r_state == ERR;

   always_comb begin
      w_n_nxt     = {w_rx_data, r_n[31:8]};
      w_word_nxt  = {w_rx_data, r_word[31:8]};
      w_acc       = w_rx_valid && !w_rx_ferr && (r_state == HDR || r_state == DATA);
      w_word_last = w_acc && r_state == DATA && r_byte_cnt == 2'd3;
      w_state_nxt = r_state;
      if (w_rx_valid) begin
         case (r_state)
            HDR:     w_state_nxt = w_rx_ferr ? ERR : r_byte_cnt != 2'd3 ? HDR :
                                   w_n_nxt > 32'(IMEM_WORDS) ? ERR : w_n_nxt == '0 ? CSUM : DATA;
            DATA:    w_state_nxt = w_rx_ferr ? ERR :
                                   (w_word_last && 32'(r_word_idx) + 32'd1 == r_n) ? CSUM : DATA;
            CSUM:    w_state_nxt = (w_rx_ferr || w_rx_data != r_csum) ? ERR : DONE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= HDR;
         r_byte_cnt <= '0;
         r_csum     <= '0;
         r_n        <= '0;
         r_word     <= '0;
         r_word_idx <= '0;
         r_we       <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_we    <= w_word_last;
         if (w_acc) begin
            r_csum     <= r_csum ^ w_rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
         end
         if (w_acc && r_state == HDR) r_n <= w_n_nxt;
         if (w_acc && r_state == DATA) r_word <= w_word_nxt;
         if (w_word_last) begin
            imem_addr  <= r_word_idx[ADDR_W-1:0];
            imem_wdata <= w_word_nxt;
            r_word_idx <= r_word_idx + 1'b1;
         end
      end
   end
endmodule
